// File: rtl/fcmp_pipe.sv
// Two-stage pipelined single-precision compare (FEQ/FLT/FLE) using sign-magnitude ordering.
// S1 registers sign bits and magnitude-relation flags; S2 registers the selected boolean result.
module fcmp_pipe #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [31:0]      x,
  input  logic [31:0]      y,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      res,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal,
  output logic             busy
);

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Magnitudes are compared on their own; the sign pair then decides which relation applies.
  function automatic logic cmp_sel(input logic [1:0] sel, input logic sx, input logic sy,
                                   input logic gt, input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    case (sel)
      OP_FEQ: r = (sx == sy) & eq;
      OP_FLT: r = (sx != sy) ? sx : (sx ? gt : lt);
      OP_FLE: r = (sx != sy) ? sx : (eq | (sx ? gt : lt));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic             vld_p1, vld_p2;
  logic             rdy_p1, rdy_p2;
  logic             load_p1, move_p2;

  logic signed [31:0] diff_p0;
  logic             gt_p0, eq_p0, lt_p0;

  logic [1:0]       op_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             sx_p1, sy_p1, gt_p1, eq_p1, lt_p1;

  logic [31:0]      res_p2;
  logic [TAG_W-1:0] tag_p2;
  logic             ill_p2;

  assign rdy_p2   = ~vld_p2 | out_ready;
  assign rdy_p1   = ~vld_p1 | rdy_p2;
  assign in_ready = rdy_p1 & ~flush;
  assign load_p1  = in_valid & in_ready;
  assign move_p2  = vld_p1 & rdy_p2 & ~flush;

  // Both magnitudes are below 2^31, so the difference never overflows 32 signed bits.
  assign diff_p0 = $signed({1'b0, x[30:0]}) - $signed({1'b0, y[30:0]});
  assign lt_p0   = diff_p0 < 0;
  assign eq_p0   = diff_p0 == 0;
  assign gt_p0   = ~lt_p0 & ~eq_p0;

  // ---- stage 1: operand relation flags ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load_p1) begin
      vld_p1 <= 1'b1;
    end else if (move_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_p1) begin
      op_p1  <= op;
      tag_p1 <= tag;
      sx_p1  <= x[31];
      sy_p1  <= y[31];
      gt_p1  <= gt_p0;
      eq_p1  <= eq_p0;
      lt_p1  <= lt_p0;
    end
  end

  // ---- stage 2: result select, registers drive the ports ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p2 <= 1'b0;
    end else if (move_p2) begin
      vld_p2 <= 1'b1;
    end else if (out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_p2 <= '0;
      tag_p2 <= '0;
      ill_p2 <= 1'b0;
    end else if (move_p2) begin
      res_p2 <= {31'b0, cmp_sel(op_p1, sx_p1, sy_p1, gt_p1, eq_p1, lt_p1)};
      tag_p2 <= tag_p1;
      ill_p2 <= (op_p1 == OP_RSV);
    end
  end

  assign out_valid = vld_p2;
  assign res       = res_p2;
  assign out_tag   = tag_p2;
  assign illegal   = ill_p2;
  assign busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: directed table, streaming, backpressure, flush and reset sequences,
// with a queue scoreboard fed by an ordering-key reference model.
module tb_fcmp_pipe;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = 2'b00;
  logic [31:0]      x = '0;
  logic [31:0]      y = '0;
  logic [TAG_W-1:0] tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      res;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;
  logic             busy;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x(x), .y(y), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .out_tag(out_tag), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Total-order key: negatives below positives, larger negative magnitude lower.
  function automatic logic [31:0] order_key(input logic [31:0] v);
    return v[31] ? {1'b0, ~v[30:0]} : {1'b1, v[30:0]};
  endfunction

  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    case (o)
      2'b00:   return (a == b) ? 32'd1 : 32'd0;
      2'b01:   return (order_key(a) <  order_key(b)) ? 32'd1 : 32'd0;
      2'b10:   return (order_key(a) <= order_key(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got tag %0h expected no output", out_tag);
        end else begin
          e = sbq.pop_front();
          check("sb_res", res, e.res);
          check("sb_tag", 32'(out_tag), 32'(e.tag));
          check("sb_ill", 32'(illegal), 32'(e.ill));
        end
      end
      if (flush) begin
        sbq.delete();
      end else if (in_valid && in_ready) begin
        e.res = model_res(op, x, y);
        e.tag = tag;
        e.ill = (op == 2'b11);
        sbq.push_back(e);
      end
    end
  end

  task automatic drive_rand(input logic [TAG_W-1:0] t);
    x = $urandom;
    case ($urandom_range(0, 3))
      0:       y = x;
      1:       y = x ^ 32'h8000_0000;
      2:       y = x ^ (32'h1 << $urandom_range(0, 31));
      default: y = $urandom;
    endcase
    op  = 2'($urandom_range(0, 3));
    tag = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!busy && sbq.size() == 0) break;
      tick();
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_queue"}, sbq.size(), 32'd0);
  endtask

  task automatic stream(input int n, input logic [TAG_W-1:0] t0);
    int sent = 0;
    int cyc = 0;
    logic acc;
    logic [TAG_W-1:0] t;
    t = t0;
    in_valid = 1'b1;
    drive_rand(t);
    while (sent < n && cyc < 500) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        t++;
        drive_rand(t);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", sent, n);
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             ill;
  } vec_t;

  initial begin
    vec_t vt[9];
    logic [31:0] first_res;
    logic [TAG_W-1:0] first_tag;
    int acc_cnt;
    logic acc;

    vt[0] = '{2'b10, 32'h3F80_0000, 32'h4000_0000, 6'h01, 32'd1, 1'b0};
    vt[1] = '{2'b10, 32'hC000_0000, 32'hBF80_0000, 6'h02, 32'd1, 1'b0};
    vt[2] = '{2'b10, 32'h4000_0000, 32'h3F80_0000, 6'h03, 32'd0, 1'b0};
    vt[3] = '{2'b10, 32'h3F80_0000, 32'h3F80_0000, 6'h04, 32'd1, 1'b0};
    vt[4] = '{2'b01, 32'h8000_0000, 32'h0000_0000, 6'h05, 32'd1, 1'b0};
    vt[5] = '{2'b00, 32'h8000_0000, 32'h0000_0000, 6'h06, 32'd0, 1'b0};
    vt[6] = '{2'b00, 32'hC049_0FDB, 32'hC049_0FDB, 6'h07, 32'd1, 1'b0};
    vt[7] = '{2'b01, 32'hC049_0FDB, 32'hC049_0FDB, 6'h08, 32'd0, 1'b0};
    vt[8] = '{2'b11, 32'h1234_5678, 32'h1234_5678, 6'h2A, 32'd0, 1'b1};

    // Asynchronous reset
    #2 rstn = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Directed table, one op at a time
    for (int i = 0; i < 9; i++) begin
      op = vt[i].op; x = vt[i].x; y = vt[i].y; tag = vt[i].tag;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("tbl_lat1_valid", 32'(out_valid), 32'd0);
      tick();
      check("tbl_valid", 32'(out_valid), 32'd1);
      check("tbl_res", res, vt[i].res);
      check("tbl_tag", 32'(out_tag), 32'(vt[i].tag));
      check("tbl_ill", 32'(illegal), 32'(vt[i].ill));
    end
    drain("tbl_drain");

    // Back-to-back streaming, tags 0..15
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin
        in_valid = 1'b1;
        drive_rand(TAG_W'(i));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 16) check("strm_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) begin
        check("strm_valid", 32'(out_valid), 32'd1);
        check("strm_tag", 32'(out_tag), 32'(i - 2));
      end
      tick();
    end
    drain("strm_drain");

    // Backpressure: out_ready low for 5 cycles from an empty pipe
    acc_cnt = 0;
    first_tag = 6'h10;
    in_valid = 1'b1;
    drive_rand(first_tag);
    first_res = model_res(op, x, y);
    for (int c = 0; c < 100 && acc_cnt < 8; c++) begin
      out_ready = (c >= 5);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c < 5) check("bp_in_ready", 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
      if (c >= 2 && c < 5) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_tag", 32'(out_tag), 32'(first_tag));
        check("bp_hold_res", res, first_res);
      end
      tick();
      if (acc) begin
        acc_cnt++;
        drive_rand(TAG_W'(6'h10 + acc_cnt));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_accepts", acc_cnt, 32'd8);
    drain("bp_drain");

    // Flush with two entries in flight, first with out_ready low, then high
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      drive_rand(6'h20);
      tick();
      drive_rand(6'h21);
      tick();
      drive_rand(6'h22);
      flush = 1'b1;
      out_ready = (k == 1);
      @(negedge clk);
      check("fl_in_ready", 32'(in_ready), 32'd0);
      check("fl_busy_before", 32'(busy), 32'd1);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_busy", 32'(busy), 32'd0);
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check("fl_no_stale", 32'(out_valid), 32'd0);
        tick();
      end
    end

    // Reset pulse mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      drive_rand(TAG_W'(6'h30 + j));
      tick();
    end
    #2 rstn = 1'b0;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_res", res, 32'd0);
    check("mrst_tag", 32'(out_tag), 32'd0);
    check("mrst_illegal", 32'(illegal), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    rstn = 1'b1;
    #1;
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    tick();
    stream(12, 6'h00);
    drain("mrst_drain");

    // Random traffic with random backpressure
    stream(200, 6'h00);
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
